// File: rtl/loop_mixer.sv
// loop_mixer: captures per-bank DDR playback samples plus the XADC aux
// sample, sums them sequentially and emits a saturated 11-bit PWM duty word.
module loop_mixer #(
  parameter int NBANKS     = 8,
  parameter int GAIN_SHIFT = 5
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [NBANKS-1:0] playing,
  input  logic              data_ready,
  input  logic [2:0]        mem_bank,
  input  logic [15:0]       mem_dq,
  input  logic              mix_data,
  input  logic [15:0]       aux_in,
  output logic [10:0]       pwm_duty,
  output logic              duty_valid,
  output logic              clip,
  output logic              busy
);

  localparam int IW = $clog2(NBANKS + 1);

  localparam logic [16:0] BIAS = 17'd32767;

  localparam logic signed [20:0] SAT_HI = 21'sd1023;
  localparam logic signed [20:0] SAT_LO = -21'sd1024;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCALE,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [16:0] ch [NBANKS];
  logic signed [16:0] f  [NBANKS];
  logic signed [16:0] aux_s;

  logic signed [20:0] acc;
  logic signed [20:0] term;
  logic signed [20:0] scaled;
  logic [IW-1:0]      idx;

  logic [10:0] sat;
  logic        sat_clip;

  logic snap_en;
  logic acc_en;
  logic scale_en;
  logic out_en;
  logic acc_last;

  logic signed [16:0] dq_s;
  logic signed [16:0] aux_now;

  // Offset-binary to signed: 0x7FFF maps to zero.
  assign dq_s    = $signed({1'b0, mem_dq} - BIAS);
  assign aux_now = $signed({1'b0, aux_in} - BIAS);

  assign acc_last = (idx == IW'(NBANKS));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (mix_data) begin
          state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (acc_last) begin
          state_nxt = S_SCALE;
        end
      end
      S_SCALE: state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    snap_en  = 1'b0;
    acc_en   = 1'b0;
    scale_en = 1'b0;
    out_en   = 1'b0;
    busy     = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy    = 1'b0;
        snap_en = mix_data;
      end
      S_ACCUM: acc_en   = 1'b1;
      S_SCALE: scale_en = 1'b1;
      S_OUT:   out_en   = 1'b1;
      default: busy     = 1'b0;
    endcase
  end

  // ---------------- channel capture ----------------
  // A bank whose play bit is low is held at zero so it never leaks.
  always_ff @(posedge clk_100MHz) begin
    for (int i = 0; i < NBANKS; i++) begin
      if (rst || !playing[i]) begin
        ch[i] <= '0;
      end else if (data_ready && mem_bank == 3'(i)) begin
        ch[i] <= dq_s;
      end
    end
  end

  // ---------------- frame snapshot ----------------
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      for (int i = 0; i < NBANKS; i++) begin
        f[i] <= '0;
      end
      aux_s <= '0;
    end else if (snap_en) begin
      for (int i = 0; i < NBANKS; i++) begin
        f[i] <= ch[i];
      end
      aux_s <= aux_now;
    end
  end

  // ---------------- term select ----------------
  // idx 0..NBANKS-1 picks a frame register, idx NBANKS picks aux.
  always_comb begin
    term = {{4{aux_s[16]}}, aux_s};
    for (int i = 0; i < NBANKS; i++) begin
      if (idx == IW'(i)) begin
        term = {{4{f[i][16]}}, f[i]};
      end
    end
  end

  // ---------------- accumulator ----------------
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (snap_en) begin
      acc <= '0;
      idx <= '0;
    end else if (acc_en) begin
      acc <= acc + term;
      idx <= idx + IW'(1);
    end
  end

  // ---------------- scale and saturate ----------------
  assign scaled = acc >>> GAIN_SHIFT;

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      sat      <= '0;
      sat_clip <= 1'b0;
    end else if (scale_en) begin
      if (scaled > SAT_HI) begin
        sat      <= SAT_HI[10:0];
        sat_clip <= 1'b1;
      end else if (scaled < SAT_LO) begin
        sat      <= SAT_LO[10:0];
        sat_clip <= 1'b1;
      end else begin
        sat      <= scaled[10:0];
        sat_clip <= 1'b0;
      end
    end
  end

  // ---------------- registered outputs ----------------
  // Adding 1024 to an 11-bit signed value is an MSB flip.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      pwm_duty   <= 11'd1024;
      clip       <= 1'b0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= out_en;
      if (out_en) begin
        pwm_duty <= {~sat[10], sat[9:0]};
        clip     <= sat_clip;
      end
    end
  end

endmodule
